// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between execute and the single-port data RAM.
// Optional ack watchdog: define LSU_TIMEOUT_EN. Mask sel: X=0 B=1 H=2 BS=3 HS=4.
module riscv_lsu_ctrl #(
  parameter int WORD_LENGTH    = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [WORD_LENGTH-1:0] req_wdata_i,
  input  logic [2:0]             req_mask_sel_i,
  output logic                   resp_valid_o,
  output logic [WORD_LENGTH-1:0] resp_rdata_o,
  output logic                   resp_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [3:0]             mem_be_o,
  output logic [WORD_LENGTH-1:0] mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [WORD_LENGTH-1:0] mem_rdata_i
);

  localparam logic [2:0] MASK_X      = 3'd0;
  localparam logic [2:0] MASK_B      = 3'd1;
  localparam logic [2:0] MASK_H      = 3'd2;
  localparam logic [2:0] MASK_B_SEXT = 3'd3;
  localparam logic [2:0] MASK_H_SEXT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [2:0]             sel_q, sel_d;
  logic [WORD_LENGTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   req_illegal;
  logic                   is_byte, is_half;
  logic [3:0]             be;
  logic [WORD_LENGTH-1:0] wrep;
  logic [WORD_LENGTH-1:0] shifted;
  logic [WORD_LENGTH-1:0] fmt;
  logic                   in_access;
  logic                   in_resp;
  logic                   timeout_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    req_illegal = 1'b1;
    unique case (req_mask_sel_i)
      MASK_X:              req_illegal = |req_addr_i[1:0];
      MASK_B, MASK_B_SEXT: req_illegal = 1'b0;
      MASK_H, MASK_H_SEXT: req_illegal = req_addr_i[0];
      default:             req_illegal = 1'b1;
    endcase
  end

  assign is_byte = (sel_q == MASK_B) || (sel_q == MASK_B_SEXT);
  assign is_half = (sel_q == MASK_H) || (sel_q == MASK_H_SEXT);

  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      is_half: begin
        be   = 4'b0011 << addr_q[1:0];
        wrep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    fmt = shifted;
    unique case (sel_q)
      MASK_B:      fmt = {{(WORD_LENGTH-8){1'b0}}, shifted[7:0]};
      MASK_H:      fmt = {{(WORD_LENGTH-16){1'b0}}, shifted[15:0]};
      MASK_B_SEXT: fmt = {{(WORD_LENGTH-8){shifted[7]}}, shifted[7:0]};
      MASK_H_SEXT: fmt = {{(WORD_LENGTH-16){shifted[15]}}, shifted[15:0]};
      default:     fmt = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          sel_d   = req_mask_sel_i;
          rdata_d = '0;
          err_d   = req_illegal;
          state_d = req_illegal ? S_RESP : S_ACCESS;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_ack_i) begin
          rdata_d = we_q ? '0 : fmt;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        if (!mem_ack_i) cnt_d = cnt_q + 1'b1;
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= MASK_X;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  // Loads read the full word, so lane enables only qualify stores.
  assign req_ready_o  = (state_q == S_IDLE);
  assign mem_req_o    = in_access;
  assign mem_we_o     = in_access & we_q;
  assign mem_addr_o   = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_be_o     = (in_access & we_q) ? be : 4'b0000;
  assign mem_wdata_o  = (in_access & we_q) ? wrep : '0;
  assign resp_valid_o = in_resp;
  assign resp_rdata_o = in_resp ? rdata_q : '0;
  assign resp_err_o   = in_resp & err_q;

endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the single-port data RAM.
- Accepts one memory op at a time and checks alignment.
- Drives RAM request, byte enables and lane-replicated write data; waits for the RAM acknowledge.
- Returns lane-aligned load data masked and sign/zero-extended per MASK_SEL, with the same semantics as the pipeline mask stage. The pipeline stalls while req_ready is low.

Parameters:
- WORD_LENGTH, 32, data width in bits; only 32 is supported (4 byte lanes).
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  op request from execute stage.
- req_ready  out  1  controller can accept an op (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WORD_LENGTH  store data, right-justified.
- req_mask_sel  in  MASK_SEL  access size/extension: MASK_X word, MASK_B, MASK_H, MASK_B_SEXT, MASK_H_SEXT.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_LENGTH  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  misalign, illegal size or timeout; valid with resp_valid.
- mem_req  out  1  RAM access request.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits forced 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  WORD_LENGTH  lane-replicated store data.
- mem_ack  in  1  RAM completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  WORD_LENGTH  RAM read word.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. All outputs 0 except req_ready = 1.
- Reset during ACCESS drops mem_req immediately and discards the op; no response is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, addr, wdata and mask_sel.
  - If the op is illegal, go to RESP with err = 1; no RAM access.
  - Otherwise go to ACCESS.
- Illegal op:
  - half-size (MASK_H/MASK_H_SEXT) with addr[0] = 1;
  - MASK_X with addr[1:0] != 0;
  - any unlisted MASK_SEL encoding.
- ACCESS:
  - mem_req = 1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack.
  - On mem_ack: capture and format the load data, then go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready is low, so a back-to-back request is accepted the cycle after RESP.
- Latency: acceptance at cycle N, mem_req at N+1. Ack at N+1 gives resp_valid at N+2. Each extra wait cycle adds one. Error ops respond at N+1.
- Byte enables: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111. SEXT variants on stores size the same as their base.
- Store data: byte is replicated to all four lanes; half is replicated to both halves; word passes through.
- Load data: shift mem_rdata right by 8*addr[1:0], then apply:
  - MASK_B: zero-extend bits [7:0].
  - MASK_H: zero-extend bits [15:0].
  - MASK_B_SEXT: sign-extend from bit 7.
  - MASK_H_SEXT: sign-extend from bit 15.
  - MASK_X: whole word.
- mem_ack outside ACCESS is ignored.
- req_valid outside IDLE is ignored; the requester holds it.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-to-16-bit counter clears on entering ACCESS and increments each ACCESS cycle without mem_ack.
  - On reaching TIMEOUT_CYCLES: drop mem_req, go to RESP with resp_err = 1 and resp_rdata = 0.
  - mem_ack in the same cycle as the limit wins; the op completes normally.
- Undefined: no counter; ACCESS waits for mem_ack indefinitely.

Test Plan:
- Load MASK_B_SEXT at addr 0x103, mem_rdata 0x80FF_1234, ack on first ACCESS cycle -> mem_addr 0x100, mem_be 4'b0000 during the load (mem_we = 0), resp_rdata 0xFFFF_FF80, resp_valid at acceptance + 2.
- Store MASK_H at 0x202, wdata 0x0000_ABCD -> mem_be 4'b1100, mem_wdata 0xABCD_ABCD, mem_we 1, resp_rdata 0, resp_err 0.
- Load MASK_X at 0x101 -> no mem_req, resp_valid with resp_err 1 one cycle after acceptance. Repeat with MASK_H at 0x001 for the same result.
- Load MASK_H at 0x002 with mem_ack delayed 5 cycles -> mem_req held 6 cycles with stable address, resp_rdata = zero-extended upper half, req_ready low throughout.
- rst_n pulsed low mid-ACCESS -> mem_req falls without a clock edge, no resp_valid, req_ready 1; the next op completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES 4 and no ack -> resp_err 1 after 4 ACCESS cycles; a repeat run with ack in the 4th cycle completes with resp_err 0.
